axi_wr_burst_master: RTL and testbench

- Parametrised AXI4 write-channel master; successor to the fixed 64-bit single-burst write channel.
- Accepts burst commands and write beats from a local client and drives AW/W/B with up to MAX_OUT bursts outstanding.
- Generates WLAST from a per-burst beat counter and rejects illegal commands before issue.
- Reports per-burst responses to the client; sits between the client and the AXI interconnect, alongside the existing write-channel FSM and ILA model.

---
 rtl/axi_wr_pkg.sv | 20 ++
 rtl/axi_wr_burst_master_fifo.sv | 56 +++++
 rtl/axi_wr_burst_master.sv | 213 +++++++++++++++++++++
 tb/tb_axi_wr_burst_master.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared constants and types for the AXI4 write burst master.
package axi_wr_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } w_state_e;

endpackage

// File: rtl/axi_wr_burst_master_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy update.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/axi_wr_burst_master.sv
// AXI4 write-channel master: validates burst commands, issues AW, streams W with WLAST, returns B.
module axi_wr_burst_master
    import axi_wr_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 64,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [AW-1:0]                cmd_addr,
    input  logic [7:0]                   cmd_len,
    input  logic [2:0]                   cmd_size,
    input  logic [1:0]                   cmd_burst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic                         cmd_err,
    input  logic [DW-1:0]                wdata_in,
    input  logic [DW/8-1:0]              wstrb_in,
    input  logic                         wvalid_in,
    output logic                         wready_out,
    output logic [AW-1:0]                axi_awaddr,
    output logic [7:0]                   axi_awlen,
    output logic [2:0]                   axi_awsize,
    output logic [1:0]                   axi_awburst,
    output logic                         axi_awvalid,
    input  logic                         axi_awready,
    output logic [DW-1:0]                axi_wdata,
    output logic [DW/8-1:0]              axi_wstrb,
    output logic                         axi_wlast,
    output logic                         axi_wvalid,
    input  logic                         axi_wready,
    input  logic [1:0]                   axi_bresp,
    input  logic                         axi_bvalid,
    output logic                         axi_bready,
    output logic [1:0]                   resp_code,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         err_sticky,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding
);
    localparam int unsigned OW       = $clog2(MAX_OUT + 1);
    localparam int unsigned CW       = OW + 1;
    localparam int unsigned MAX_SIZE = $clog2(DW / 8);

    w_state_e      state_q, state_d;
    logic [7:0]    beat_q, beat_d;
    logic          aw_valid_q, aw_valid_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]    aw_len_q, aw_len_d;
    logic [2:0]    aw_size_q, aw_size_d;
    logic [1:0]    aw_burst_q, aw_burst_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          cmd_err_q, cmd_err_d;
    logic          sticky_q, sticky_d;
    logic          resp_valid_q, resp_valid_d;
    logic [1:0]    resp_code_q, resp_code_d;

    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic          aw_hs, b_hs, b_ok, w_hs, in_data, cmd_acc;
    logic          size_bad, len_ok, misaligned, cross_4k, cmd_illegal;
    logic [AW-1:0] size_mask;
    logic [15:0]   burst_bytes, burst_end;

    sync_fifo #(.WIDTH(8), .DEPTH(MAX_OUT)) u_len_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .din    (cmd_len),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Command legality, evaluated on the raw command inputs.
    always_comb begin
        size_bad    = cmd_size > 3'(MAX_SIZE);
        len_ok      = (cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) || (cmd_len == 8'd15);
        size_mask   = (AW'(1) << cmd_size) - AW'(1);
        misaligned  = (cmd_addr & size_mask) != '0;
        burst_bytes = (16'(cmd_len) + 16'd1) << cmd_size;
        burst_end   = 16'(cmd_addr[11:0]) + burst_bytes;
        cross_4k    = burst_end > 16'(BOUNDARY_4K);
        cmd_illegal = size_bad || (cmd_burst == 2'd3)
                   || ((cmd_burst == BURST_WRAP) && (!len_ok || misaligned))
                   || ((cmd_burst == BURST_INCR) && cross_4k);
    end

    assign aw_hs      = aw_valid_q && axi_awready;
    assign axi_bready = !resp_valid_q || resp_ready;
    assign b_hs       = axi_bvalid && axi_bready;
    assign b_ok       = b_hs && (outstanding_q != '0);
    assign cmd_ready  = (!aw_valid_q || axi_awready) && !fifo_full
                     && ((CW'(outstanding_q) + CW'(aw_valid_q)) < CW'(MAX_OUT));
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign fifo_push  = cmd_acc && !cmd_illegal;

    assign in_data    = state_q == W_DATA;
    assign w_hs       = in_data && wvalid_in && axi_wready;
    assign axi_wvalid = in_data && wvalid_in;
    assign wready_out = in_data && axi_wready;
    assign axi_wdata  = wdata_in;
    assign axi_wstrb  = wstrb_in;
    assign axi_wlast  = in_data && (beat_q == 8'd0);

    assign axi_awvalid = aw_valid_q;
    assign axi_awaddr  = aw_addr_q;
    assign axi_awlen   = aw_len_q;
    assign axi_awsize  = aw_size_q;
    assign axi_awburst = aw_burst_q;
    assign outstanding = outstanding_q;
    assign cmd_err     = cmd_err_q;
    assign err_sticky  = sticky_q;
    assign resp_valid  = resp_valid_q;
    assign resp_code   = resp_code_q;

    // Next-state: AW register, W beat FSM, outstanding counter, response and error tracking.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        fifo_pop      = 1'b0;
        aw_valid_d    = aw_valid_q;
        aw_addr_d     = aw_addr_q;
        aw_len_d      = aw_len_q;
        aw_size_d     = aw_size_q;
        aw_burst_d    = aw_burst_q;
        resp_valid_d  = resp_valid_q;
        resp_code_d   = resp_code_q;
        cmd_err_d     = cmd_acc && cmd_illegal;
        sticky_d      = sticky_q;
        outstanding_d = outstanding_q + OW'(aw_hs) - OW'(b_ok);

        if (fifo_push) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = cmd_addr;
            aw_len_d   = cmd_len;
            aw_size_d  = cmd_size;
            aw_burst_d = cmd_burst;
        end else if (aw_hs) begin
            aw_valid_d = 1'b0;
        end

        unique case (state_q)
            W_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    beat_d   = fifo_dout;
                    state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (beat_q == 8'd0) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            beat_d   = fifo_dout;
                        end else begin
                            state_d = W_IDLE;
                        end
                    end else begin
                        beat_d = beat_q - 8'd1;
                    end
                end
            end
            default: state_d = W_IDLE;
        endcase

        if (b_ok) begin
            resp_valid_d = 1'b1;
            resp_code_d  = axi_bresp;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end

        if ((cmd_acc && cmd_illegal) || (b_ok && axi_bresp[1]) || (b_hs && !b_ok)) begin
            sticky_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= W_IDLE;
            beat_q        <= '0;
            aw_valid_q    <= 1'b0;
            aw_addr_q     <= '0;
            aw_len_q      <= '0;
            aw_size_q     <= '0;
            aw_burst_q    <= '0;
            outstanding_q <= '0;
            cmd_err_q     <= 1'b0;
            sticky_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_code_q   <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            aw_valid_q    <= aw_valid_d;
            aw_addr_q     <= aw_addr_d;
            aw_len_q      <= aw_len_d;
            aw_size_q     <= aw_size_d;
            aw_burst_q    <= aw_burst_d;
            outstanding_q <= outstanding_d;
            cmd_err_q     <= cmd_err_d;
            sticky_q      <= sticky_d;
            resp_valid_q  <= resp_valid_d;
            resp_code_q   <= resp_code_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Bench for axi_wr_burst_master: directed scenarios plus randomized traffic against a transaction model.
module tb_axi_wr_burst_master;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic resetn;
    logic [AW-1:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [2:0] cmd_size;
    logic [1:0] cmd_burst;
    logic cmd_valid, cmd_ready, cmd_err;
    logic [DW-1:0] wdata_in;
    logic [DW/8-1:0] wstrb_in;
    logic wvalid_in, wready_out;
    logic [AW-1:0] axi_awaddr;
    logic [7:0] axi_awlen;
    logic [2:0] axi_awsize;
    logic [1:0] axi_awburst;
    logic axi_awvalid, axi_awready;
    logic [DW-1:0] axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic axi_wlast, axi_wvalid, axi_wready;
    logic [1:0] axi_bresp;
    logic axi_bvalid, axi_bready;
    logic [1:0] resp_code;
    logic resp_valid, resp_ready, err_sticky;
    logic [$clog2(MAX_OUT+1)-1:0] outstanding;

    axi_wr_burst_master #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_err(cmd_err),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in), .wready_out(wready_out),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .resp_code(resp_code), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .err_sticky(err_sticky), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Transaction-level model state.
    int m_out;
    bit m_sticky, m_cmd_err, m_resp_valid, m_aw_valid, m_active;
    logic [1:0] m_resp_code;
    logic [AW-1:0] m_aw_addr;
    int m_aw_len, m_aw_size, m_aw_burst, m_rem;
    int lenq[$];

    // Beat observation for directed scenarios.
    int beats, lasts, last_at, first_cyc, last_cyc;
    logic [63:0] lastmask;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit legal(input int a12, input int l, input int s, input int b);
        int bytes;
        bytes = (l + 1) << s;
        if (s > 3) return 1'b0;
        if (b == 3) return 1'b0;
        if (b == 2) begin
            if (!(l == 1 || l == 3 || l == 7 || l == 15)) return 1'b0;
            if ((a12 % (1 << s)) != 0) return 1'b0;
        end
        if (b == 1 && (a12 + bytes) > 4096) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_out = 0; m_sticky = 0; m_cmd_err = 0; m_resp_valid = 0; m_aw_valid = 0;
        m_active = 0; m_rem = 0; m_resp_code = 2'd0;
        lenq.delete();
    endtask

    // One clock: compare outputs against the model, then advance the model over the edge.
    task automatic step();
        bit exp_ready, exp_bready, acc, ill, awhs, bhs, whs;
        int old_out;
        #1;
        if (!resetn) begin
            model_reset();
        end else begin
            exp_ready  = (!m_aw_valid || axi_awready) && (lenq.size() < MAX_OUT)
                      && ((m_out + int'(m_aw_valid)) < MAX_OUT);
            exp_bready = !m_resp_valid || resp_ready;
            chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
            chk("cmd_err", 64'(cmd_err), 64'(m_cmd_err));
            chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
            chk("outstanding", 64'(outstanding), 64'(m_out));
            chk("awvalid", 64'(axi_awvalid), 64'(m_aw_valid));
            chk("bready", 64'(axi_bready), 64'(exp_bready));
            chk("resp_valid", 64'(resp_valid), 64'(m_resp_valid));
            chk("wvalid", 64'(axi_wvalid), 64'(m_active && wvalid_in));
            chk("wready_out", 64'(wready_out), 64'(m_active && axi_wready));
            if (m_aw_valid) begin
                chk("awaddr", 64'(axi_awaddr), 64'(m_aw_addr));
                chk("awlen", 64'(axi_awlen), 64'(m_aw_len));
                chk("awsize", 64'(axi_awsize), 64'(m_aw_size));
                chk("awburst", 64'(axi_awburst), 64'(m_aw_burst));
            end
            if (m_active) begin
                chk("wlast", 64'(axi_wlast), 64'(m_rem == 0));
                chk("wdata", 64'(axi_wdata), 64'(wdata_in));
                chk("wstrb", 64'(axi_wstrb), 64'(wstrb_in));
            end
            if (m_resp_valid) chk("resp_code", 64'(resp_code), 64'(m_resp_code));

            acc  = cmd_valid && exp_ready;
            ill  = !legal(int'(cmd_addr[11:0]), int'(cmd_len), int'(cmd_size), int'(cmd_burst));
            awhs = m_aw_valid && axi_awready;
            bhs  = exp_bready && axi_bvalid;
            whs  = m_active && wvalid_in && axi_wready;
            old_out = m_out;

            if (!m_active) begin
                if (lenq.size() > 0) begin m_rem = lenq.pop_front(); m_active = 1; end
            end else if (whs) begin
                if (m_rem == 0) begin
                    if (lenq.size() > 0) m_rem = lenq.pop_front();
                    else m_active = 0;
                end else m_rem--;
            end

            if (acc && !ill) begin
                lenq.push_back(int'(cmd_len));
                m_aw_valid = 1; m_aw_addr = cmd_addr; m_aw_len = int'(cmd_len);
                m_aw_size = int'(cmd_size); m_aw_burst = int'(cmd_burst);
            end else if (awhs) m_aw_valid = 0;

            m_cmd_err = acc && ill;
            if (m_cmd_err) m_sticky = 1;

            if (bhs && old_out > 0) begin
                m_resp_valid = 1; m_resp_code = axi_bresp;
                if (axi_bresp[1]) m_sticky = 1;
            end else if (resp_ready) m_resp_valid = 0;
            if (bhs && old_out == 0) m_sticky = 1;

            m_out = old_out + int'(awhs) - int'(bhs && old_out > 0);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clr_obs();
        beats = 0; lasts = 0; last_at = 0; first_cyc = 0; last_cyc = 0; lastmask = 64'd0;
    endtask

    task automatic obs_step();
        #1;
        if (axi_wvalid && axi_wready) begin
            beats++;
            if (beats == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (axi_wlast) begin lasts++; last_at = beats; lastmask = lastmask | (64'd1 << beats); end
        end
        step();
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_size = 3'd3; cmd_burst = 2'd1;
        wvalid_in = 0; wdata_in = '0; wstrb_in = '1;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 2'd0; resp_ready = 1;
    endtask

    task automatic do_reset();
        resetn = 0;
        step();
        resetn = 1;
    endtask

    task automatic send_cmd(input logic [31:0] a, input int l, input int s, input int b);
        int n;
        n = 0;
        cmd_addr = a; cmd_len = 8'(l); cmd_size = 3'(s); cmd_burst = 2'(b); cmd_valid = 1;
        #1;
        while (!cmd_ready && n < 50) begin step(); n++; #1; end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL send_cmd: cmd_ready stuck at 0 after 50 cycles");
        end
        step();
        cmd_valid = 0;
    endtask

    task automatic drain(input int n, input logic [1:0] resp);
        for (int i = 0; i < n; i++) begin
            axi_awready = 1; axi_wready = 1; wvalid_in = 1; wdata_in = {$urandom, $urandom};
            axi_bvalid = (m_out > 0); axi_bresp = resp; resp_ready = 1;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        @(negedge clk);

        // Reset state.
        do_reset();
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_cmd_err", 64'(cmd_err), 64'd0);

        // Single INCR burst of 4 beats.
        axi_awready = 1; axi_wready = 1; wvalid_in = 1; resp_ready = 0;
        cmd_addr = 32'h1000; cmd_len = 8'd3; cmd_size = 3'd3; cmd_burst = 2'd1; cmd_valid = 1;
        #1 chk("t1_cmd_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 0;
        chk("t1_awvalid", 64'(axi_awvalid), 64'd1);
        chk("t1_awaddr", 64'(axi_awaddr), 64'h1000);
        chk("t1_awlen", 64'(axi_awlen), 64'd3);
        clr_obs();
        for (int i = 0; i < 12; i++) obs_step();
        chk("t1_beats", 64'(beats), 64'd4);
        chk("t1_wlast_count", 64'(lasts), 64'd1);
        chk("t1_wlast_at", 64'(last_at), 64'd4);
        chk("t1_outstanding", 64'(outstanding), 64'd1);
        axi_bvalid = 1; axi_bresp = 2'd0;
        step();
        axi_bvalid = 0;
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        chk("t1_resp_code", 64'(resp_code), 64'd0);
        chk("t1_outstanding_done", 64'(outstanding), 64'd0);
        resp_ready = 1;
        step();
        chk("t1_resp_consumed", 64'(resp_valid), 64'd0);
        idle_inputs();

        // 4KB crossing is rejected.
        cmd_addr = 32'h0FF8; cmd_len = 8'd1; cmd_size = 3'd3; cmd_burst = 2'd1; cmd_valid = 1;
        step();
        cmd_valid = 0;
        chk("t2_cmd_err", 64'(cmd_err), 64'd1);
        chk("t2_sticky", 64'(err_sticky), 64'd1);
        chk("t2_awvalid", 64'(axi_awvalid), 64'd0);
        chk("t2_outstanding", 64'(outstanding), 64'd0);
        step();
        chk("t2_cmd_err_pulse", 64'(cmd_err), 64'd0);
        do_reset();

        // WRAP length legality.
        cmd_addr = 32'h38; cmd_len = 8'd5; cmd_size = 3'd3; cmd_burst = 2'd2; cmd_valid = 1;
        step();
        chk("t3_wrap5_err", 64'(cmd_err), 64'd1);
        cmd_len = 8'd7;
        step();
        cmd_valid = 0;
        chk("t3_wrap7_err", 64'(cmd_err), 64'd0);
        chk("t3_wrap7_awvalid", 64'(axi_awvalid), 64'd1);
        chk("t3_wrap7_awburst", 64'(axi_awburst), 64'd2);
        drain(30, 2'd0);
        do_reset();

        // Back-to-back commands len 0,1,2 with B held off.
        axi_awready = 1; axi_wready = 1; wvalid_in = 1; resp_ready = 1;
        clr_obs();
        for (int i = 0; i < 14; i++) begin
            cmd_valid = (i < 3); cmd_addr = 32'h2000; cmd_len = 8'(i); cmd_size = 3'd3; cmd_burst = 2'd1;
            obs_step();
        end
        cmd_valid = 0;
        chk("t4_beats", 64'(beats), 64'd6);
        chk("t4_wlast_mask", lastmask, 64'h4A);
        chk("t4_no_gap", 64'(last_cyc - first_cyc), 64'd5);
        chk("t4_outstanding", 64'(outstanding), 64'd3);
        axi_bvalid = 1;
        for (int i = 0; i < 3; i++) step();
        axi_bvalid = 0;
        chk("t4_outstanding_done", 64'(outstanding), 64'd0);
        idle_inputs();

        // Outstanding limit stalls commands until a B frees a slot.
        do_reset();
        axi_awready = 1; axi_wready = 1; wvalid_in = 1;
        for (int i = 0; i < MAX_OUT; i++) send_cmd(32'h3000, 0, 3, 1);
        for (int i = 0; i < 6; i++) step();
        cmd_addr = 32'h3000; cmd_len = 8'd0; cmd_valid = 1;
        #1 chk("t5_full_ready", 64'(cmd_ready), 64'd0);
        axi_bvalid = 1;
        step();
        axi_bvalid = 0;
        #1 chk("t5_freed_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 0;
        drain(30, 2'd0);

        // Simultaneous AW and B handshakes keep the count.
        do_reset();
        axi_awready = 1; axi_wready = 1; wvalid_in = 1;
        send_cmd(32'h4000, 0, 3, 1);
        for (int i = 0; i < 6; i++) step();
        chk("t6_out_one", 64'(outstanding), 64'd1);
        axi_awready = 0;
        send_cmd(32'h4100, 0, 3, 1);
        axi_awready = 1; axi_bvalid = 1;
        step();
        axi_bvalid = 0;
        chk("t6_out_same", 64'(outstanding), 64'd1);
        drain(30, 2'd0);

        // Reset in the middle of a burst.
        do_reset();
        axi_awready = 1; axi_wready = 1; wvalid_in = 1;
        send_cmd(32'h5000, 7, 3, 1);
        clr_obs();
        for (int i = 0; i < 20 && beats < 2; i++) obs_step();
        chk("t7_two_beats", 64'(beats), 64'd2);
        resetn = 0;
        step();
        resetn = 1;
        #1;
        chk("t7_wvalid", 64'(axi_wvalid), 64'd0);
        chk("t7_awvalid", 64'(axi_awvalid), 64'd0);
        chk("t7_outstanding", 64'(outstanding), 64'd0);
        for (int i = 0; i < 3; i++) step();
        send_cmd(32'h5000, 0, 3, 1);
        clr_obs();
        for (int i = 0; i < 8; i++) obs_step();
        chk("t7_after_beats", 64'(beats), 64'd1);
        chk("t7_after_wlast", 64'(last_at), 64'd1);
        drain(20, 2'd0);

        // SLVERR makes the error flag sticky across later OKAYs.
        do_reset();
        send_cmd(32'h6000, 0, 3, 1);
        drain(20, 2'd2);
        chk("t8_sticky_set", 64'(err_sticky), 64'd1);
        send_cmd(32'h6100, 1, 3, 1);
        drain(20, 2'd0);
        chk("t8_sticky_held", 64'(err_sticky), 64'd1);
        do_reset();
        chk("t8_sticky_reset", 64'(err_sticky), 64'd0);

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            resetn      = ($urandom_range(0, 299) != 0);
            cmd_valid   = ($urandom_range(0, 2) == 0);
            cmd_burst   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            cmd_size    = 3'($urandom_range(0, 4));
            cmd_len     = (cmd_burst == 2'd2) ? 8'($urandom_range(0, 4) * 4 - 1 + (($urandom_range(0, 7) == 0) ? 2 : 0))
                                              : 8'($urandom_range(0, 7));
            cmd_addr    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_3FF8);
            wvalid_in   = ($urandom_range(0, 3) != 0);
            wdata_in    = {$urandom, $urandom};
            wstrb_in    = 8'($urandom);
            axi_awready = ($urandom_range(0, 2) != 0);
            axi_wready  = ($urandom_range(0, 3) != 0);
            axi_bvalid  = ($urandom_range(0, 3) == 0);
            axi_bresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            resp_ready  = ($urandom_range(0, 2) != 0);
            step();
        end
        resetn = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
